// File: rtl/fwd_scoreboard_pkg.sv
// Shared pipeline definitions: operand forwarding source encoding used by the
// forwarding/scoreboard block and its consumers.
package fwd_scoreboard_pkg;

  localparam int SRC_W = 3;

  typedef enum logic [SRC_W-1:0] {
    FROM_ZERO     = 3'd0,
    FROM_RF       = 3'd1,
    FROM_ID_EX_ID = 3'd2,
    FROM_ALU_OUT  = 3'd3,
    FROM_WB       = 3'd4,
    FROM_HOLD     = 3'd5
  } forwarding_control_e;

endpackage

// File: rtl/fwd_scoreboard_if.sv
// Operand-read, producer and multi-cycle tracking signals between the pipeline
// (master) and the forwarding scoreboard (slave).
interface fwd_scoreboard_if #(
  parameter int NPORT = 2,
  parameter int DW    = 64,
  parameter int NREG  = 32
);
  localparam int AW = $clog2(NREG);

  logic [NPORT*AW-1:0] rs_addr;
  logic [NPORT*DW-1:0] rs_rf_data;
  logic                ex_valid;
  logic [AW-1:0]       ex_rd;
  logic [DW-1:0]       ex_data;
  logic                ex_is_load;
  logic                mem_valid;
  logic [AW-1:0]       mem_rd;
  logic [DW-1:0]       mem_data;
  logic                mem_ready;
  logic                wb_valid;
  logic [AW-1:0]       wb_rd;
  logic [DW-1:0]       wb_data;
  logic                mc_issue;
  logic [AW-1:0]       mc_rd;
  logic                mc_done;
  logic [AW-1:0]       mc_done_rd;
  logic                mc_kill;
  logic [NPORT*DW-1:0] rs_data;
  logic [NPORT*3-1:0]  rs_src;
  logic                stall;
  logic [AW:0]         busy_count;

  modport master (
    output rs_addr, rs_rf_data,
    output ex_valid, ex_rd, ex_data, ex_is_load,
    output mem_valid, mem_rd, mem_data, mem_ready,
    output wb_valid, wb_rd, wb_data,
    output mc_issue, mc_rd, mc_done, mc_done_rd, mc_kill,
    input  rs_data, rs_src, stall, busy_count
  );

  modport slave (
    input  rs_addr, rs_rf_data,
    input  ex_valid, ex_rd, ex_data, ex_is_load,
    input  mem_valid, mem_rd, mem_data, mem_ready,
    input  wb_valid, wb_rd, wb_data,
    input  mc_issue, mc_rd, mc_done, mc_done_rd, mc_kill,
    output rs_data, rs_src, stall, busy_count
  );

endinterface

// File: rtl/fwd_port_sel.sv
// Single read-port operand select: EX > MEM > WB > HOLD > RF, x0 reads as zero,
// with the per-port stall term for unready producers and busy multi-cycle targets.
module fwd_port_sel
  import fwd_scoreboard_pkg::*;
#(
  parameter int DW = 64,
  parameter int AW = 5
) (
  input  logic [AW-1:0]        addr,
  input  logic [DW-1:0]        rf_data,
  input  logic                 ex_valid,
  input  logic [AW-1:0]        ex_rd,
  input  logic [DW-1:0]        ex_data,
  input  logic                 ex_is_load,
  input  logic                 mem_valid,
  input  logic [AW-1:0]        mem_rd,
  input  logic [DW-1:0]        mem_data,
  input  logic                 mem_ready,
  input  logic                 wb_valid,
  input  logic [AW-1:0]        wb_rd,
  input  logic [DW-1:0]        wb_data,
  input  logic                 hold_valid,
  input  logic [AW-1:0]        hold_rd,
  input  logic [DW-1:0]        hold_data,
  input  logic                 sb_busy,
  output logic [DW-1:0]        data,
  output forwarding_control_e  src,
  output logic                 stall
);

  logic ex_hit, mem_hit, wb_hit, hold_hit;

  assign ex_hit   = ex_valid   && (ex_rd   == addr) && (ex_rd   != '0);
  assign mem_hit  = mem_valid  && (mem_rd  == addr) && (mem_rd  != '0);
  assign wb_hit   = wb_valid   && (wb_rd   == addr) && (wb_rd   != '0);
  assign hold_hit = hold_valid && (hold_rd == addr) && (hold_rd != '0);

  // A ready EX/MEM value is newer than any outstanding multi-cycle result, so only
  // the lower-priority sources defer to the scoreboard bit.
  always_comb begin
    data  = rf_data;
    src   = FROM_RF;
    stall = 1'b0;
    if (addr == '0) begin
      data = '0;
      src  = FROM_ZERO;
    end else if (ex_hit) begin
      data  = ex_data;
      src   = FROM_ID_EX_ID;
      stall = ex_is_load;
    end else if (mem_hit) begin
      data  = mem_data;
      src   = FROM_ALU_OUT;
      stall = !mem_ready;
    end else if (wb_hit) begin
      data  = wb_data;
      src   = FROM_WB;
      stall = sb_busy;
    end else if (hold_hit) begin
      data  = hold_data;
      src   = FROM_HOLD;
      stall = sb_busy;
    end else begin
      stall = sb_busy;
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Operand forwarding network with a multi-cycle scoreboard and a one-entry HOLD
// register that covers the cycle after the register-file write.
module fwd_scoreboard
  import fwd_scoreboard_pkg::*;
#(
  parameter int NPORT = 2,
  parameter int DW    = 64,
  parameter int NREG  = 32
) (
  input  logic          clk,
  input  logic          reset,
  fwd_scoreboard_if.slave bus
);

  localparam int AW = $clog2(NREG);

  logic [NREG-1:0]     sb_q, sb_d;
  logic                hold_valid_q;
  logic [AW-1:0]       hold_rd_q;
  logic [DW-1:0]       hold_data_q;
  logic                wb_take;

  logic [DW-1:0]       port_data  [NPORT];
  forwarding_control_e port_src   [NPORT];
  logic [NPORT-1:0]    port_stall;

  function automatic logic [AW:0] popcount(input logic [NREG-1:0] v);
    logic [AW:0] c;
    c = '0;
    for (int i = 0; i < NREG; i++) c = c + {{AW{1'b0}}, v[i]};
    return c;
  endfunction

  // Kill first, then completion, then issue: a same-cycle issue always survives.
  always_comb begin
    sb_d = sb_q;
    if (bus.mc_kill) sb_d = '0;
    if (bus.mc_done) sb_d[bus.mc_done_rd] = 1'b0;
    if (bus.mc_issue && (bus.mc_rd != '0)) sb_d[bus.mc_rd] = 1'b1;
  end

  assign wb_take = bus.wb_valid && (bus.wb_rd != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      sb_q         <= '0;
      hold_valid_q <= 1'b0;
    end else begin
      sb_q         <= sb_d;
      hold_valid_q <= wb_take;
    end
  end

  always_ff @(posedge clk) begin
    if (wb_take) begin
      hold_rd_q   <= bus.wb_rd;
      hold_data_q <= bus.wb_data;
    end
  end

  for (genvar p = 0; p < NPORT; p++) begin : g_port
    fwd_port_sel #(.DW(DW), .AW(AW)) u_sel (
      .addr       (bus.rs_addr[p*AW +: AW]),
      .rf_data    (bus.rs_rf_data[p*DW +: DW]),
      .ex_valid   (bus.ex_valid),
      .ex_rd      (bus.ex_rd),
      .ex_data    (bus.ex_data),
      .ex_is_load (bus.ex_is_load),
      .mem_valid  (bus.mem_valid),
      .mem_rd     (bus.mem_rd),
      .mem_data   (bus.mem_data),
      .mem_ready  (bus.mem_ready),
      .wb_valid   (bus.wb_valid),
      .wb_rd      (bus.wb_rd),
      .wb_data    (bus.wb_data),
      .hold_valid (hold_valid_q),
      .hold_rd    (hold_rd_q),
      .hold_data  (hold_data_q),
      .sb_busy    (sb_q[bus.rs_addr[p*AW +: AW]]),
      .data       (port_data[p]),
      .src        (port_src[p]),
      .stall      (port_stall[p])
    );
  end

  always_comb begin
    bus.rs_data = '0;
    bus.rs_src  = '0;
    for (int p = 0; p < NPORT; p++) begin
      bus.rs_data[p*DW +: DW] = port_data[p];
      bus.rs_src[p*3 +: 3]    = port_src[p];
    end
  end

  assign bus.stall      = |port_stall;
  assign bus.busy_count = popcount(sb_q);

endmodule
